// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard: two combinational read ports, one write-back port.
// Optional write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic                  rbusy1,
  output logic                  rbusy2,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  iss_en,
  input  logic [ADDR_WIDTH-1:0] iss_addr,
  input  logic                  flush
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Every entry must clear asynchronously, so storage is a flop array rather than block RAM.
  logic [DATA_WIDTH-1:0] rf_reg [DEPTH];
  logic [DEPTH-1:0]      busy_reg;
  logic [DEPTH-1:0]      busy_next;

  logic [ADDR_WIDTH-1:0] raddr_v [2];
  logic [DATA_WIDTH-1:0] rdata_v [2];
  logic                  rbusy_v [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_reg[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (wen && (waddr == ADDR_WIDTH'(i))) begin
          rf_reg[i] <= wdata;
        end
      end
    end
  end

  // Flush beats issue, issue beats write-back: a new producer keeps the register busy.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        assign busy_next[gi] = flush                                         ? 1'b0 :
                               (iss_en && (iss_addr == ADDR_WIDTH'(gi)))     ? 1'b1 :
                               (wen && (waddr == ADDR_WIDTH'(gi)))           ? 1'b0 :
                                                                               busy_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign raddr_v[0] = raddr1;
  assign raddr_v[1] = raddr2;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rport
      logic [DATA_WIDTH-1:0] stored_data;
      assign stored_data = (raddr_v[gi] == '0) ? '0 : rf_reg[raddr_v[gi]];
`ifdef REG_FILE_BYPASS_EN
      logic byp;
      assign byp         = wen && (waddr != '0) && (raddr_v[gi] == waddr);
      assign rdata_v[gi] = byp ? wdata : stored_data;
      // A forwarded value is ready unless another issue to the same register lands this cycle.
      assign rbusy_v[gi] = byp ? (iss_en && (iss_addr == waddr)) : busy_reg[raddr_v[gi]];
`else
      assign rdata_v[gi] = stored_data;
      assign rbusy_v[gi] = busy_reg[raddr_v[gi]];
`endif
    end
  endgenerate

  assign rdata1 = rdata_v[0];
  assign rdata2 = rdata_v[1];
  assign rbusy1 = rbusy_v[0];
  assign rbusy2 = rbusy_v[1];

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: table-driven vectors through a scoreboard queue,
// plus hand-written reset and forwarding sequences.
module tb_reg_file_sb;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] raddr1, raddr2, waddr, iss_addr;
  logic [DW-1:0] rdata1, rdata2, wdata;
  logic          rbusy1, rbusy2, wen, iss_en, flush;

  reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .rbusy1(rbusy1), .rbusy2(rbusy2),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          iss_en;
    logic [AW-1:0] iss_addr;
    logic          flush;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] e_d1;
    logic          e_b1;
    logic [DW-1:0] e_d2;
    logic          e_b2;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d1;
    logic          b1;
    logic [DW-1:0] d2;
    logic          b2;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[20];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic ie, input logic [AW-1:0] ia, input logic fl,
                              input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                              input logic [DW-1:0] d1, input logic b1,
                              input logic [DW-1:0] d2, input logic b2);
    vec_t v;
    v.wen = w;  v.waddr = wa; v.wdata = wd; v.iss_en = ie; v.iss_addr = ia; v.flush = fl;
    v.ra1 = a1; v.ra2 = a2;   v.e_d1 = d1;  v.e_b1 = b1;   v.e_d2 = d2;     v.e_b2 = b2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    wen = 1'b0; waddr = '0; wdata = '0; iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  // Called just after a rising edge; drives one cycle, checks mid-cycle, returns after the next edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    wen = v.wen; waddr = v.waddr; wdata = v.wdata;
    iss_en = v.iss_en; iss_addr = v.iss_addr; flush = v.flush;
    raddr1 = v.ra1; raddr2 = v.ra2;
    sb_q.push_back('{d1: v.e_d1, b1: v.e_b1, d2: v.e_d2, b2: v.e_b2});
    @(negedge clk);
    e = sb_q.pop_front();
    $display("tx %s: ra1=%0d rd1=%08h rb1=%0b ra2=%0d rd2=%08h rb2=%0b", tag,
             raddr1, rdata1, rbusy1, raddr2, rdata2, rbusy2);
    chk({tag, ".rdata1"}, rdata1, e.d1);
    chk({tag, ".rbusy1"}, {31'd0, rbusy1}, {31'd0, e.b1});
    chk({tag, ".rdata2"}, rdata2, e.d2);
    chk({tag, ".rbusy2"}, {31'd0, rbusy2}, {31'd0, e.b2});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //             wen wa  wdata         ie ia fl ra1 ra2  d1            b1 d2            b2
    tbl[0]  = mk(0, 0,  32'h0,        0, 0, 0, 0,  0,  32'h0,        0, 32'h0,        0);
    tbl[1]  = mk(1, 0,  32'hFFFFFFFF, 1, 0, 0, 5,  7,  32'h0,        0, 32'h0,        0);
    tbl[2]  = mk(0, 0,  32'h0,        0, 0, 0, 0,  0,  32'h0,        0, 32'h0,        0);
    tbl[3]  = mk(0, 0,  32'h0,        1, 7, 0, 0,  7,  32'h0,        0, 32'h0,        0);
    tbl[4]  = mk(0, 0,  32'h0,        0, 0, 0, 0,  7,  32'h0,        0, 32'h0,        1);
    tbl[5]  = mk(0, 0,  32'h0,        0, 0, 0, 0,  7,  32'h0,        0, 32'h0,        1);
    tbl[6]  = mk(1, 7,  32'h12345678, 0, 0, 0, 1,  1,  32'h0,        0, 32'h0,        0);
    tbl[7]  = mk(0, 0,  32'h0,        0, 0, 0, 0,  7,  32'h0,        0, 32'h12345678, 0);
    tbl[8]  = mk(1, 3,  32'hA5A5A5A5, 1, 3, 0, 7,  0,  32'h12345678, 0, 32'h0,        0);
    tbl[9]  = mk(0, 0,  32'h0,        0, 0, 0, 3,  3,  32'hA5A5A5A5, 1, 32'hA5A5A5A5, 1);
    tbl[10] = mk(0, 0,  32'h0,        1, 2, 0, 3,  2,  32'hA5A5A5A5, 1, 32'h0,        0);
    tbl[11] = mk(0, 0,  32'h0,        1, 9, 0, 2,  9,  32'h0,        1, 32'h0,        0);
    tbl[12] = mk(0, 0,  32'h0,        1, 31,0, 9,  31, 32'h0,        1, 32'h0,        0);
    tbl[13] = mk(1, 20, 32'hCAFEF00D, 1, 9, 1, 31, 2,  32'h0,        1, 32'h0,        1);
    tbl[14] = mk(0, 0,  32'h0,        0, 0, 0, 9,  31, 32'h0,        0, 32'h0,        0);
    tbl[15] = mk(0, 0,  32'h0,        0, 0, 0, 2,  20, 32'h0,        0, 32'hCAFEF00D, 0);
    tbl[16] = mk(0, 0,  32'h0,        1, 10,0, 3,  10, 32'hA5A5A5A5, 0, 32'h0,        0);
    tbl[17] = mk(0, 0,  32'h0,        0, 0, 0, 10, 20, 32'h0,        1, 32'hCAFEF00D, 0);
    tbl[18] = mk(1, 10, 32'h0BADCAFE, 0, 0, 0, 20, 3,  32'hCAFEF00D, 0, 32'hA5A5A5A5, 0);
    tbl[19] = mk(0, 0,  32'h0,        0, 0, 0, 10, 10, 32'h0BADCAFE, 0, 32'h0BADCAFE, 0);

    rst_n = 1'b0;
    drive_idle();
    raddr1 = 5; raddr2 = 7;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold.rdata1", rdata1, 32'h0);
    chk("reset_hold.rbusy1", {31'd0, rbusy1}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset between edges wipes data and busy immediately.
    apply(mk(1, 5, 32'hDEADBEEF, 1, 5, 0, 3, 7, 32'hA5A5A5A5, 0, 32'h12345678, 0), "rst_prep");
    drive_idle();
    raddr1 = 5; raddr2 = 20;
    #1;
    chk("pre_rst.rdata1", rdata1, 32'hDEADBEEF);
    chk("pre_rst.rbusy1", {31'd0, rbusy1}, 32'h1);
    rst_n = 1'b0;
    #1;
    $display("tx async_reset: ra1=5 rd1=%08h rb1=%0b ra2=20 rd2=%08h", rdata1, rbusy1, rdata2);
    chk("async_rst.rdata1", rdata1, 32'h0);
    chk("async_rst.rbusy1", {31'd0, rbusy1}, 32'h0);
    chk("async_rst.rdata2", rdata2, 32'h0);
    // Write and issue presented across an edge while reset is held must be discarded.
    wen = 1'b1; waddr = 6; wdata = 32'h66666666; iss_en = 1'b1; iss_addr = 6;
    @(posedge clk);
    #1;
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(mk(0, 0, 32'h0, 0, 0, 0, 6, 5, 32'h0, 0, 32'h0, 0), "rst_discard");

    // Forwarding: same-cycle write visible only when bypass is built in.
    apply(mk(1, 4, 32'h0000BEEF, 0, 0, 0, 4, 0,
             BYP ? 32'h0000BEEF : 32'h0, 0, 32'h0, 0), "byp_wr");
    apply(mk(1, 4, 32'h00001111, 1, 4, 0, 4, 4,
             BYP ? 32'h00001111 : 32'h0000BEEF, BYP,
             BYP ? 32'h00001111 : 32'h0000BEEF, BYP), "byp_wr_iss");
    apply(mk(0, 0, 32'h0, 0, 0, 0, 4, 0, 32'h00001111, 1, 32'h0, 0), "byp_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised general-purpose register file with a per-register busy scoreboard, for the pipelined CPU core. Provides two combinational read ports and one synchronous write-back port. A scoreboard marks registers awaiting a pending write and lets decode stall on read-after-write hazards. Sits between decode (read ports, issue) and write-back (write port).

## Interface
- DATA_WIDTH, 32, width of each register
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH; register 0 hard-wired to zero
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- raddr1  input  ADDR_WIDTH  read port 1 address
- raddr2  input  ADDR_WIDTH  read port 2 address
- rdata1  output  DATA_WIDTH  read port 1 data
- rdata2  output  DATA_WIDTH  read port 2 data
- rbusy1  output  1  register at raddr1 has a pending write
- rbusy2  output  1  register at raddr2 has a pending write
- wen  input  1  write-back enable
- waddr  input  ADDR_WIDTH  write-back address
- wdata  input  DATA_WIDTH  write-back data
- iss_en  input  1  issue: mark iss_addr busy
- iss_addr  input  ADDR_WIDTH  destination register of issuing instruction
- flush  input  1  clear all busy bits (pipeline flush)

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH data array plus one busy bit per register.
- Write: on rising clk with wen=1 and waddr!=0, rf[waddr] <= wdata. Writes to address 0 are discarded.
- Read: rdataN = 0 when raddrN==0, else rf[raddrN] (combinational).
- Busy bit update per register i (i!=0), per clock edge, priority highest first:
  - flush=1 -> busy[i] <= 0
  - iss_en=1 and iss_addr==i -> busy[i] <= 1
  - wen=1 and waddr==i -> busy[i] <= 0
  - else hold
- Issue and write-back to the same register in one cycle: busy ends 1 (new producer wins); data is still written.
- flush does not block the data write in the same cycle.
- busy[0] is constantly 0; iss_en with iss_addr=0 has no effect.
- rbusyN = busy[raddrN], combinational; 0 for raddrN==0.

## Timing
- Reset: rst_n=0 immediately clears every register to 0 and every busy bit to 0, independent of clk; rdata1/2=0, rbusy1/2=0 while held. Inputs are ignored until the first rising edge after rst_n deasserts.
- Reset asserted mid-operation discards any write or issue on that edge.
- Read latency: 0 cycles (combinational from raddr and state).
- Write latency: data visible on read ports the cycle after the write edge (without bypass).
- Busy set by issue in cycle N is visible on rbusy from cycle N+1. Busy cleared by write-back in cycle N is visible from cycle N+1, unless bypass is enabled (see Configuration).

## Configuration
- REG_FILE_BYPASS_EN defined: write-to-read forwarding.
  - If wen=1, waddr!=0, and raddrN==waddr, then rdataN=wdata in the same cycle.
  - rbusyN=0 in that cycle, unless iss_en=1 and iss_addr==waddr in the same cycle; then rbusyN=1.
- REG_FILE_BYPASS_EN undefined: reads return stored state only. The same-cycle write is visible the next cycle.

## Test plan
- Reset: write 0xDEADBEEF to r5, then pulse rst_n low between edges -> rdata1 at raddr1=5 becomes 0 immediately; rbusy1=0.
- r0 guard: wen=1, waddr=0, wdata=0xFFFFFFFF; iss_en=1, iss_addr=0 -> next cycle rdata1 at raddr1=0 is 0 and rbusy1=0.
- Scoreboard: iss_en r7 in cycle 1 -> rbusy2=1 at raddr2=7 from cycle 2. wen r7=0x12345678 in cycle 4 -> rbusy2=0 and rdata2=0x12345678 from cycle 5.
- Same-cycle issue and write-back on r3 (wdata=0xA5A5A5A5) -> next cycle rdata1=0xA5A5A5A5, rbusy1=1.
- Flush: r2, r9, r31 busy; flush=1 with iss_en r9 in the same cycle -> next cycle all three rbusy=0.
- Bypass (REG_FILE_BYPASS_EN): wen r4=0x0000BEEF with raddr1=4 in the same cycle -> rdata1=0x0000BEEF in that cycle. Without the macro: old value that cycle, 0x0000BEEF the next.
